// File: rtl/traffic_pkg.sv
// Shared encodings for the timed highway/country-road signal controller.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package traffic_pkg;

  localparam int STATE_W = 3;

  // Lamp groups are {R,Y,G}
  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;
  localparam logic [2:0] OFF    = 3'b000;

  typedef enum logic [STATE_W-1:0] {
    HW_GREEN  = 3'd0,
    HW_YELLOW = 3'd1,
    ALL_RED1  = 3'd2,
    CR_GREEN  = 3'd3,
    CR_YELLOW = 3'd4,
    ALL_RED2  = 3'd5,
    FLASH     = 3'd6
  } state_t;

endpackage

// File: rtl/tsc_phase_counter.sv
// Phase duration counter: clears on request, saturates at a limit, compares to a threshold.
// Latency: count and compares reflect the value registered at the previous edge.
// Backpressure: none; advances every cycle unless cleared or saturated.
module tsc_phase_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             clr,
  input  logic [CNT_W-1:0] sat_lim,
  input  logic [CNT_W-1:0] lim,
  output logic [CNT_W-1:0] cnt,
  output logic             at_sat,
  output logic             ge_lim
);

  assign at_sat = (cnt >= sat_lim);
  assign ge_lim = (cnt >= lim);

  // Count up from zero after every clear, holding once the saturation limit is reached
  always_ff @(posedge clk) begin
    if (!clear_n || clr) begin
      cnt <= '0;
    end else if (!at_sat) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_signal_timed.sv
// Highway/country-road signal controller with programmable phase times and maintenance flash.
// Latency: lamps and phase are registered from the next state, changing on the same edge as the state.
// Backpressure: none; inputs are sampled every edge.
module traffic_signal_timed
  import traffic_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int MIN_HW_GREEN = 8,
  parameter int MIN_CR_GREEN = 4,
  parameter int MAX_CR_GREEN = 10,
  parameter int YELLOW_T     = 3,
  parameter int ALLRED_T     = 2,
  parameter int FLASH_HALF   = 4
) (
  input  logic         clk,
  input  logic         clear_n,
  input  logic         signal,
  input  logic         flash,
  output logic [2:0]   highway,
  output logic [2:0]   country_road,
  output logic [2:0]   phase
);

  state_t           state, state_nxt;
  logic             blink, blink_nxt;
  logic [CNT_W-1:0] cnt, lim, sat_lim;
  logic             at_sat, ge_lim, cnt_clr;
  logic [2:0]       hw_nxt, cr_nxt;

  // Flash reuses the counter as its half-period timer, so clear it on each toggle too
  assign cnt_clr = (state_nxt != state) || ((state == FLASH) && ge_lim);

  tsc_phase_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk     (clk),
    .clear_n (clear_n),
    .clr     (cnt_clr),
    .sat_lim (sat_lim),
    .lim     (lim),
    .cnt     (cnt),
    .at_sat  (at_sat),
    .ge_lim  (ge_lim)
  );

  // Per-state thresholds, next-state selection and next blink phase
  always_comb begin
    lim       = '1;
    sat_lim   = '1;
    state_nxt = state;
    blink_nxt = 1'b1;
    case (state)
      HW_GREEN: begin
        lim     = CNT_W'(MIN_HW_GREEN - 1);
        sat_lim = CNT_W'(MIN_HW_GREEN - 1);
        if (ge_lim && signal) state_nxt = HW_YELLOW;
      end
      HW_YELLOW: begin
        lim = CNT_W'(YELLOW_T - 1);
        if (ge_lim) state_nxt = ALL_RED1;
      end
      ALL_RED1: begin
        lim = CNT_W'(ALLRED_T - 1);
        if (ge_lim) state_nxt = CR_GREEN;
      end
      CR_GREEN: begin
        lim     = CNT_W'(MIN_CR_GREEN - 1);
        sat_lim = CNT_W'(MAX_CR_GREEN - 1);
        if ((ge_lim && !signal) || at_sat) state_nxt = CR_YELLOW;
      end
      CR_YELLOW: begin
        lim = CNT_W'(YELLOW_T - 1);
        if (ge_lim) state_nxt = ALL_RED2;
      end
      ALL_RED2: begin
        lim = CNT_W'(ALLRED_T - 1);
        if (ge_lim) state_nxt = HW_GREEN;
      end
      FLASH: begin
        lim = CNT_W'(FLASH_HALF - 1);
        // Leaving flash goes through a full all-red before highway green
        if (!flash) state_nxt = ALL_RED2;
      end
      default: state_nxt = HW_GREEN;
    endcase
    if (flash) state_nxt = FLASH;
    // Blink starts high on entry and toggles each half-period while flashing
    if ((state == FLASH) && (state_nxt == FLASH)) begin
      blink_nxt = ge_lim ? ~blink : blink;
    end
  end

  // Lamp decode from the state being entered so outputs align with the state register
  always_comb begin
    hw_nxt = RED;
    cr_nxt = RED;
    case (state_nxt)
      HW_GREEN:  hw_nxt = GREEN;
      HW_YELLOW: hw_nxt = YELLOW;
      CR_GREEN:  cr_nxt = GREEN;
      CR_YELLOW: cr_nxt = YELLOW;
      FLASH: begin
        hw_nxt = blink_nxt ? YELLOW : OFF;
        cr_nxt = blink_nxt ? RED    : OFF;
      end
      default: begin
        hw_nxt = RED;
        cr_nxt = RED;
      end
    endcase
  end

  // State, blink and registered outputs; reset overrides flash and any phase in progress
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state        <= HW_GREEN;
      blink        <= 1'b1;
      highway      <= GREEN;
      country_road <= RED;
      phase        <= 3'(HW_GREEN);
    end else begin
      state        <= state_nxt;
      blink        <= blink_nxt;
      highway      <= hw_nxt;
      country_road <= cr_nxt;
      phase        <= 3'(state_nxt);
    end
  end

endmodule

// File: tb/tb_traffic_signal_timed.sv
module tb_traffic_signal_timed;

  logic       clk;
  logic       clear_n;
  logic       signal;
  logic       flash;
  logic [2:0] highway;
  logic [2:0] country_road;
  logic [2:0] phase;

  int vectors    = 0;
  int miscompares = 0;

  traffic_signal_timed dut (
    .clk          (clk),
    .clear_n      (clear_n),
    .signal       (signal),
    .flash        (flash),
    .highway      (highway),
    .country_road (country_road),
    .phase        (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {highway, country_road, phase} for a phase code
  function automatic logic [8:0] exp_vec(input int ph, input bit blk);
    case (ph)
      0: return {3'b001, 3'b100, 3'd0};
      1: return {3'b010, 3'b100, 3'd1};
      2: return {3'b100, 3'b100, 3'd2};
      3: return {3'b100, 3'b001, 3'd3};
      4: return {3'b100, 3'b010, 3'd4};
      5: return {3'b100, 3'b100, 3'd5};
      default: return blk ? {3'b010, 3'b100, 3'd6} : {3'b000, 3'b000, 3'd6};
    endcase
  endfunction

  // Phase within the 28-cycle sustained-demand loop, counted from reset release
  function automatic int sustained_phase(input int k);
    int p;
    p = k % 28;
    if (p < 8)  return 0;
    if (p < 11) return 1;
    if (p < 13) return 2;
    if (p < 23) return 3;
    if (p < 26) return 4;
    return 5;
  endfunction

  function automatic int short_phase(input int k);
    if (k < 8)  return 0;
    if (k < 11) return 1;
    if (k < 13) return 2;
    if (k < 17) return 3;
    return 4;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [8:0] e);
    logic [8:0] got;
    got = {highway, country_road, phase};
    vectors++;
    assert (got === e) else begin
      miscompares++;
      $error("FAIL %s: got hw=%b cr=%b ph=%0d, want hw=%b cr=%b ph=%0d",
             tag, got[8:6], got[5:3], got[2:0], e[8:6], e[5:3], e[2:0]);
    end
  endtask

  // One reset edge; the sample after it is cycle 0 of HW_GREEN
  task automatic apply_reset();
    clear_n = 1'b0;
    signal  = 1'b0;
    flash   = 1'b0;
    tick();
    clear_n = 1'b1;
  endtask

  initial begin
    clear_n = 1'b0;
    signal  = 1'b0;
    flash   = 1'b1;
    tick();
    tick();
    check("reset_state", exp_vec(0, 1'b1));

    // Idle: no demand keeps highway green
    clear_n = 1'b1;
    flash   = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      check("idle", exp_vec(0, 1'b1));
    end

    // Sustained demand: two full 28-cycle loops with country green at max
    apply_reset();
    signal = 1'b1;
    for (int k = 0; k < 56; k++) begin
      check("sustained", exp_vec(sustained_phase(k), 1'b1));
      tick();
    end

    // Short demand, with signal toggling through yellow/all-red
    apply_reset();
    signal = 1'b1;
    for (int k = 0; k < 18; k++) begin
      check("short_demand", exp_vec(short_phase(k), 1'b1));
      if (k >= 8 && k <= 12) signal = (k % 2 == 0);
      if (k >= 13) signal = 1'b0;
      tick();
    end

    // Late demand: highway yellow on the edge right after signal rises
    apply_reset();
    signal = 1'b0;
    for (int k = 0; k < 20; k++) begin
      check("late_wait", exp_vec(0, 1'b1));
      tick();
    end
    signal = 1'b1;
    tick();
    check("late_yellow", exp_vec(1, 1'b1));

    // Flash entry during country green, three half-periods, then exit via all-red
    apply_reset();
    signal = 1'b1;
    for (int k = 0; k < 14; k++) tick();
    check("pre_flash_cr_green", exp_vec(3, 1'b1));
    flash = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("flash_blink", exp_vec(6, ((i / 4) % 2) == 0));
    end
    flash  = 1'b0;
    signal = 1'b0;
    tick();
    check("flash_exit_red1", exp_vec(5, 1'b1));
    tick();
    check("flash_exit_red2", exp_vec(5, 1'b1));
    tick();
    check("flash_exit_green", exp_vec(0, 1'b1));

    // Reset mid country-yellow, then a full-length highway green
    apply_reset();
    signal = 1'b1;
    for (int k = 0; k < 24; k++) tick();
    check("mid_cr_yellow", exp_vec(4, 1'b1));
    clear_n = 1'b0;
    tick();
    check("midreset", exp_vec(0, 1'b1));
    clear_n = 1'b1;
    for (int i = 1; i < 8; i++) begin
      tick();
      check("post_reset_green", exp_vec(0, 1'b1));
    end
    tick();
    check("post_reset_yellow", exp_vec(1, 1'b1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
